// File: rtl/pipe_pkg.sv
// Shared types for pipe_stage_skid: stage state encoding, default NOP payload, occupancy width.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  localparam logic [15:0] PIPE_NOP_INSTR = 16'h0800;
  localparam int          PIPE_OCC_W     = 2;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot (payload + err + valid); clear/reset return it to NOP_VAL with err=0, valid=0.
// Latency: load visible the cycle after the edge. Backpressure: none, the owner decides when to load/hold.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int                 DATA_W  = 16,
  parameter logic [DATA_W-1:0]  NOP_VAL = DATA_W'(PIPE_NOP_INSTR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              ld,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_err,
  output logic [DATA_W-1:0] data,
  output logic              err,
  output logic              vld
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      data <= NOP_VAL;
      err  <= 1'b0;
      vld  <= 1'b0;
    end else if (ld) begin
      data <= ld_data;
      err  <= ld_err;
      vld  <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, flush and NOP fill; PIPE_STAGE_SKID_EN adds a skid slot.
// Latency: 1 cycle, 1 beat/cycle. Backpressure: skid build has registered in_ready (absorbs one extra beat);
// default build has in_ready = !out_valid | out_ready.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = 16,
  parameter logic [DATA_W-1:0] NOP_VAL = DATA_W'(PIPE_NOP_INSTR)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_err,
  output logic [PIPE_OCC_W-1:0] occupancy
);

  pipe_state_e       state, state_n;
  logic              accept, pop;
  logic              main_ld, main_clr, main_vld;
  logic [DATA_W-1:0] main_din;
  logic              main_err_din;

  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_valid = main_vld;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_ld, skid_clr, skid_vld, skid_err, main_from_skid;
  logic [DATA_W-1:0] skid_data;

  // in_ready depends only on the state register, never on out_ready
  assign in_ready     = (state != FULL);
  assign main_din     = main_from_skid ? skid_data : in_data;
  assign main_err_din = main_from_skid ? skid_err  : in_err;
  assign occupancy    = {1'b0, main_vld} + {1'b0, skid_vld};

  pipe_slot #(.DATA_W(DATA_W), .NOP_VAL(NOP_VAL)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .clr     (skid_clr),
    .ld      (skid_ld),
    .ld_data (in_data),
    .ld_err  (in_err),
    .data    (skid_data),
    .err     (skid_err),
    .vld     (skid_vld)
  );
`else
  assign in_ready     = ~main_vld | out_ready;
  assign main_din     = in_data;
  assign main_err_din = in_err;
  assign occupancy    = {1'b0, main_vld};
`endif

  pipe_slot #(.DATA_W(DATA_W), .NOP_VAL(NOP_VAL)) u_main (
    .clk     (clk),
    .rst     (rst),
    .clr     (main_clr),
    .ld      (main_ld),
    .ld_data (main_din),
    .ld_err  (main_err_din),
    .data    (out_data),
    .err     (out_err),
    .vld     (main_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    main_ld  = 1'b0;
    main_clr = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    skid_ld        = 1'b0;
    skid_clr       = 1'b0;
    main_from_skid = 1'b0;
`endif
    if (flush) begin
      // a beat accepted this cycle is dropped; a pop this cycle still completes
      state_n  = EMPTY;
      main_clr = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
      skid_clr = 1'b1;
`endif
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_n = ONE;
            main_ld = 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_ld = 1'b1;
          end else if (accept) begin
`ifdef PIPE_STAGE_SKID_EN
            state_n = FULL;
            skid_ld = 1'b1;
`else
            main_ld = 1'b1;
`endif
          end else if (pop) begin
            state_n  = EMPTY;
            main_clr = 1'b1;
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        FULL: begin
          if (pop) begin
            state_n        = ONE;
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
`endif
        default: begin
          state_n  = EMPTY;
          main_clr = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: queue model of held beats plus directed scenarios; honours PIPE_STAGE_SKID_EN.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0000;
  logic        in_err = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_err;
  logic [1:0]  occupancy;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(16), .NOP_VAL(16'h0800)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_err    (in_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .occupancy (occupancy)
  );

  int          total = 0;
  int          bad = 0;
  bit          chk_en = 1'b0;
  logic [16:0] q[$];
  logic [16:0] dq[$];
  logic [16:0] exp_dq[$];
  logic [16:0] m_head;
  bit          m_acc, m_pop;

`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  function automatic bit m_in_ready();
    if (SKID) return q.size() < 2;
    return (q.size() == 0) || out_ready;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: held beats as a FIFO queue, delivered beats logged in order
  always @(posedge clk) begin
    m_acc = in_valid && m_in_ready();
    m_pop = (q.size() > 0) && out_ready;
    if (rst) begin
      q.delete();
    end else begin
      if (m_pop) begin
        dq.push_back(q[0]);
        void'(q.pop_front());
      end
      if (flush) q.delete();
      else if (m_acc) q.push_back({in_err, in_data});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      m_head = (q.size() != 0) ? q[0] : 17'h00800;
      check("m_out_valid", 32'(out_valid), 32'(q.size() != 0));
      check("m_out_data",  32'(out_data),  32'(m_head[15:0]));
      check("m_out_err",   32'(out_err),   32'(m_head[16]));
      check("m_in_ready",  32'(in_ready),  32'(m_in_ready()));
      check("m_occupancy", 32'(occupancy), 32'(q.size()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [15:0] d, input bit e, input bit r);
    in_valid  = v;
    in_data   = d;
    in_err    = e;
    out_ready = r;
  endtask

  initial begin
    logic [15:0] bp[4];
    int          idx;
    bit          took;
    bp[0] = 16'hA001; bp[1] = 16'hA002; bp[2] = 16'hA003; bp[3] = 16'hA004;

    // reset / idle
    step(); step();
    chk_en = 1'b1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'h0800);
    check("rst_out_err",   32'(out_err),   32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_occ",       32'(occupancy), 32'd0);
    rst = 1'b0;

    // streaming, no bubbles
    drive(1, 16'h1111, 0, 1); step();
    check("str_1111", 32'(out_data), 32'h1111);
    drive(1, 16'h2222, 0, 1); step();
    check("str_2222", 32'(out_data), 32'h2222);
    drive(1, 16'h3333, 0, 1); step();
    check("str_3333", 32'(out_data), 32'h3333);
    check("str_valid", 32'(out_valid), 32'd1);
    drive(0, 16'h0000, 0, 1); step();
    check("str_drain", 32'(out_valid), 32'd0);

    // error propagation and ready behaviour while holding one beat
    drive(1, 16'h0042, 1, 0); step();
    check("err_data", 32'(out_data), 32'h0042);
    check("err_flag", 32'(out_err),  32'd1);
    drive(0, 16'h0000, 0, 0); #1;
    check("hold_in_ready", 32'(in_ready), SKID ? 32'd1 : 32'd0);
    out_ready = 1'b1; #1;
    check("pop_in_ready", 32'(in_ready), 32'd1);
    step();
    check("err_clear", 32'(out_err), 32'd0);

    // simultaneous pop and accept
    drive(1, 16'h5555, 0, 1); step();
    drive(1, 16'h6666, 0, 1); step();
    check("pa_occ",  32'(occupancy), 32'd1);
    check("pa_data", 32'(out_data),  32'h6666);
    drive(0, 16'h0000, 0, 1); step();

    // backpressure: out_ready low for three cycles
    idx = 0;
    for (int k = 0; k < 12; k++) begin
      out_ready = !(k >= 1 && k <= 3);
      in_valid  = (idx < 4);
      in_data   = (idx < 4) ? bp[idx] : 16'h0000;
      in_err    = 1'b0;
      #1;
      took = in_valid && in_ready;
      step();
      if (took) idx++;
      if (k == 1) begin
        check("bp_head",  32'(out_data),  32'hA001);
        check("bp_occ",   32'(occupancy), SKID ? 32'd2 : 32'd1);
        check("bp_ready", 32'(in_ready),  32'd0);
      end
      if (k == 2) begin
        check("bp_head2", 32'(out_data),  32'hA001);
        check("bp_occ2",  32'(occupancy), SKID ? 32'd2 : 32'd1);
      end
    end
    in_valid = 1'b0;
    check("bp_all_taken", 32'(idx), 32'd4);

    // flush with a stalled output
    drive(1, 16'hC001, 0, 0); step();
    drive(1, 16'hC002, 0, 0); step();
    check("fl_pre_occ", 32'(occupancy), SKID ? 32'd2 : 32'd1);
    flush = 1'b1; drive(1, 16'hBEEF, 0, 0); step(); flush = 1'b0;
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_data",  32'(out_data),  32'h0800);
    check("fl_occ",   32'(occupancy), 32'd0);
    check("fl_ready", 32'(in_ready),  32'd1);
    flush = 1'b1; drive(1, 16'hE001, 0, 1); step(); flush = 1'b0;
    check("fl_acc_drop", 32'(out_valid), 32'd0);
    drive(1, 16'hF001, 0, 1); step();
    check("fl_f001", 32'(out_data), 32'hF001);
    flush = 1'b1; drive(0, 16'h0000, 0, 1); step(); flush = 1'b0;
    check("fl_pop_valid", 32'(out_valid), 32'd0);
    step();

    // reset mid-stream overrides everything
    drive(1, 16'hD001, 0, 0); step();
    rst = 1'b1; flush = 1'b1; drive(1, 16'hD002, 1, 1); step();
    check("mrst_occ",   32'(occupancy), 32'd0);
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_err",   32'(out_err),   32'd0);
    rst = 1'b0; flush = 1'b0; drive(0, 16'h0000, 0, 1); step(); step();

    // delivered beat order, with no flushed/reset beats
    exp_dq = '{17'h01111, 17'h02222, 17'h03333, 17'h10042, 17'h05555, 17'h06666,
               17'h0A001, 17'h0A002, 17'h0A003, 17'h0A004, 17'h0F001};
    check("dlv_count", 32'(dq.size()), 32'(exp_dq.size()));
    for (int i = 0; i < exp_dq.size() && i < dq.size(); i++)
      check($sformatf("dlv_%0d", i), 32'(dq[i]), 32'(exp_dq[i]));

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
